// File: rtl/gray_pkg.sv
// gray_pkg: shared types and conversion constants for the grayscale stream engine
package gray_pkg;
  typedef enum logic [1:0] {LUMA, AVG, MAX, GREEN} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  localparam int W_R      = 77;
  localparam int W_G      = 150;
  localparam int W_B      = 29;
  localparam int W_AVG    = 171;
  localparam int RND_LUMA = 128;
  localparam int RND_AVG  = 256;
endpackage

// File: rtl/gray_fifo.sv
// gray_fifo: synchronous show-ahead FIFO with occupancy count
module gray_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_pop;
  assign valid  = cnt_q != '0;
  assign do_pop = pop & valid;
  assign count  = cnt_q;
  // head is masked while empty so stale entries never reach the port
  assign dout   = valid ? mem_q[rd_q] : '0;
  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/gray_stream_ctrl.sv
// gray_stream_ctrl: frame sequencer reading RGB memories, converting to gray
// and streaming the result through a credit-controlled output FIFO
module gray_stream_ctrl
  import gray_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 9,
  parameter int NUM_PIX    = 256,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_r,
  input  logic [DATA_W-1:0] mem_g,
  input  logic [DATA_W-1:0] mem_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int LW  = DATA_W + 10;
  localparam int AVW = DATA_W + 11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CW-1:0] infl_q, infl_d, fifo_count;
  logic [MEM_LAT-1:0] pv_q, pv_d, pl_q, pl_d;
  logic cv_q, cv_d, cl_q, cl_d;
  logic [DATA_W-1:0] cd_q, cd_d, mx_rg, mx;
  logic [LW-1:0] luma;
  logic [AVW-1:0] avg;
  logic [DATA_W:0] fifo_dout;
  logic issue, is_last, pop, fifo_last;
  // issued-but-unpushed reads reserve FIFO space, so a push never overflows
  assign issue     = state_q == S_RUN && (fifo_count + infl_q) < CW'(FIFO_DEPTH);
  assign is_last   = idx_q == LAST_ADDR;
  assign pop       = m_valid & m_ready;
  assign fifo_last = fifo_dout[DATA_W];
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign mem_en    = issue;
  assign mem_addr  = idx_q;
  assign m_data    = fifo_dout[DATA_W-1:0];
  assign m_last    = fifo_last;
  assign luma  = LW'(W_R) * LW'(mem_r) + LW'(W_G) * LW'(mem_g) + LW'(W_B) * LW'(mem_b) + LW'(RND_LUMA);
  assign avg   = (AVW'(mem_r) + AVW'(mem_g) + AVW'(mem_b)) * AVW'(W_AVG) + AVW'(RND_AVG);
  assign mx_rg = mem_r > mem_g ? mem_r : mem_g;
  assign mx    = mx_rg > mem_b ? mx_rg : mem_b;
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE:  if (start) begin
        state_d = S_RUN;
        mode_d  = mode_e'(mode);
        idx_d   = '0;
      end
      S_RUN:   if (issue) begin
        idx_d   = is_last ? idx_q : idx_q + 1'b1;
        state_d = is_last ? S_DRAIN : S_RUN;
      end
      S_DRAIN: state_d = pop && fifo_last ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    infl_d = infl_q + CW'(issue) - CW'(cv_q);
    pv_d   = MEM_LAT'({pv_q, issue});
    pl_d   = MEM_LAT'({pl_q, issue & is_last});
    cv_d   = pv_q[MEM_LAT-1];
    cl_d   = pl_q[MEM_LAT-1];
    cd_d   = mode_q == LUMA ? luma[DATA_W+7:8] :
             mode_q == AVG  ? avg[DATA_W+8:9]  :
             mode_q == MAX  ? mx : mem_g;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= LUMA;
      idx_q   <= '0;
      infl_q  <= '0;
      pv_q    <= '0;
      pl_q    <= '0;
      cv_q    <= 1'b0;
      cl_q    <= 1'b0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      infl_q  <= infl_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      cv_q    <= cv_d;
      cl_q    <= cl_d;
      cd_q    <= cd_d;
    end
  end
  gray_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cv_q),
    .din     ({cl_q, cd_q}),
    .pop     (pop),
    .dout    (fifo_dout),
    .valid   (m_valid),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_gray_stream_ctrl.sv
// tb_gray_stream_ctrl: randomized frame tests against a spec-level scoreboard
module tb_gray_stream_ctrl;
  localparam int DW = 8, AW = 9, NP = 256, ML = 1, FD = 4;
  logic clk = 0, reset_n = 0, start = 0, m_ready = 0;
  logic [1:0] mode = 0;
  logic busy, done, mem_en, m_valid, m_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_r, mem_g, mem_b, m_data;
  logic [DW-1:0] rm [NP], gm [NP], bm [NP];
  logic [8:0] exp_q [$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, t0 = 0, first_v = -1, done_c = -1, done_n = 0, en_n = 0;
  int hs_n = 0, first_hs = -1, last_hs = -1, rdy_mode = 1;
  logic [DW-1:0] d0, d1;
  int corner [4] = '{77, 85, 255, 0};

  always #5 clk = ~clk;

  gray_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_PIX(NP), .MEM_LAT(ML), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_r(mem_r), .mem_g(mem_g), .mem_b(mem_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      mem_r <= rm[mem_addr[7:0]];
      mem_g <= gm[mem_addr[7:0]];
      mem_b <= bm[mem_addr[7:0]];
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int gray_ref(int md, int r, int g, int b);
    int m;
    m = r > g ? r : g;
    m = m > b ? m : b;
    case (md)
      0: return ((77 * r + 150 * g + 29 * b + 128) >> 8) & 255;
      1: return (((r + g + b) * 171 + 256) >> 9) & 255;
      2: return m;
      default: return g;
    endcase
  endfunction

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      m_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
      if (mem_en) en_n++;
      if (done) begin
        done_n++;
        done_c = cyc - t0;
      end
      if (m_valid && first_v < 0) first_v = cyc - t0;
      if (m_valid && m_ready) begin
        if (hs_n == 0) d0 = m_data;
        if (hs_n == 1) d1 = m_data;
        if (exp_q.size() == 0) check("sb_extra", 0, 1);
        else begin
          e = exp_q.pop_front();
          check("sb_data", m_data, e[7:0]);
          check("sb_last", m_last, e[8]);
        end
        if (first_hs < 0) first_hs = cyc - t0;
        last_hs = cyc - t0;
        hs_n++;
      end
    end
  end

  task automatic start_frame(int md);
    int g;
    logic [7:0] g8;
    @(negedge clk); #1;
    exp_q.delete();
    for (int i = 0; i < NP; i++) begin
      g  = gray_ref(md, rm[i], gm[i], bm[i]);
      g8 = g[7:0];
      exp_q.push_back({i == NP - 1, g8});
    end
    hs_n = 0; done_n = 0; en_n = 0; first_v = -1; first_hs = -1; last_hs = -1; done_c = -1;
    t0 = cyc;
    start = 1;
    mode = 2'(md);
    @(negedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(string tag);
    int k = 0;
    while (done_n == 0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_done_seen"}, done_n != 0, 1);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < NP; i++) begin
      rm[i] = 8'(i); gm[i] = 8'(i); bm[i] = 8'(i);
    end
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1;
    rdy_mode = 1;
    start_frame(0);
    check("ramp_busy_c1", busy, 1);
    check("ramp_mem_en_c1", mem_en, 1);
    check("ramp_addr_c1", mem_addr, 0);
    wait_done("ramp");
    check("ramp_first_valid_cyc", first_v, 4);
    check("ramp_done_cyc", done_c, NP + 4);
    for (int i = 0; i < NP; i++) begin
      rm[i] = 8'($urandom); gm[i] = 8'($urandom); bm[i] = 8'($urandom);
    end
    rm[0] = 255; gm[0] = 0; bm[0] = 0;
    rm[1] = 255; gm[1] = 255; bm[1] = 255;
    for (int md = 0; md < 4; md++) begin
      rdy_mode = 2;
      start_frame(md);
      wait_done("corner");
      check("corner_red", d0, corner[md]);
      check("corner_white", d1, 255);
    end
    rdy_mode = 0;
    start_frame(2);
    repeat (19) @(negedge clk);
    #1;
    check("bp_mem_en_pulses", en_n, FD);
    check("bp_m_valid", m_valid, 1);
    check("bp_no_handshake", hs_n, 0);
    rdy_mode = 1;
    wait_done("bp");
    check("bp_gap_free", last_hs - first_hs, NP - 1);
    rdy_mode = 2;
    start_frame(1);
    repeat (30) @(negedge clk);
    #1;
    start = 1;
    mode = 2;
    @(negedge clk); #1;
    start = 0;
    wait_done("restart_ignored");
    rdy_mode = 1;
    start_frame(0);
    k = 0;
    while (!(mem_en && mem_addr == 100) && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    check("reach_px100", k < 500, 1);
    reset_n = 0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    @(negedge clk); #1;
    reset_n = 1;
    repeat (3) @(negedge clk);
    #1;
    check("post_reset_no_valid", m_valid, 0);
    check("post_reset_hs", hs_n < 120, 1);
    start_frame(3);
    check("rerun_addr_c1", mem_addr, 0);
    check("rerun_mem_en_c1", mem_en, 1);
    wait_done("rerun");
    check("rerun_first_valid_cyc", first_v, 4);
    check("rerun_sample_count", hs_n, NP);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
